// File: rtl/wb_slave_regfile_pkg.sv
// Shared widths, FSM state codes and register indices for the Wishbone
// register-file slave.
package wb_slave_regfile_pkg;

  localparam int ADDRESS_WIDTH = 8;
  localparam int DATA_WIDTH    = 32;
  localparam int SELECT_WIDTH  = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    WBS_IDLE = 2'd0,
    WBS_RESP = 2'd1,
    WBS_HOLD = 2'd2
  } wbs_state_e;

  localparam logic [3:0] MAILBOX_IDX   = 4'd0;
  localparam logic [3:0] CTRL_IDX      = 4'd15;
  localparam int         CTRL_IE_BIT   = 0;
  localparam int         CTRL_PEND_BIT = 1;

endpackage

// File: rtl/wb_slave_regfile_if.sv
// Wishbone classic-cycle bus between a master and the register-file slave.
// Signal names follow the slave's point of view (_I into the slave).
interface wb_slave_regfile_if;
  import wb_slave_regfile_pkg::*;

  logic [ADDRESS_WIDTH-1:0] ADR_I;
  logic [DATA_WIDTH-1:0]    DAT_I;
  logic                     WE_I;
  logic [SELECT_WIDTH-1:0]  SEL_I;
  logic                     STB_I;
  logic                     CYC_I;
  logic [DATA_WIDTH-1:0]    DAT_O;
  logic                     ACK_O;
  logic                     ERR_O;
  logic                     INTR_O;

  modport master (
    output ADR_I, DAT_I, WE_I, SEL_I, STB_I, CYC_I,
    input  DAT_O, ACK_O, ERR_O, INTR_O
  );

  modport slave (
    input  ADR_I, DAT_I, WE_I, SEL_I, STB_I, CYC_I,
    output DAT_O, ACK_O, ERR_O, INTR_O
  );
endinterface

// File: rtl/wb_slave_regfile_mem.sv
// DEPTH x (8*LANES) register array split into independent byte lanes.
// Each lane has its own write enable; the read port is combinational.
module wbs_regfile_mem #(
  parameter int DEPTH = 16,
  parameter int LANES = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IW-1:0]         widx_i,
  input  logic [LANES-1:0]      wsel_i,
  input  logic [LANES-1:0][7:0] wdat_i,
  input  logic [IW-1:0]         ridx_i,
  output logic [LANES-1:0][7:0] rdat_o
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DEPTH-1:0][7:0] lane_q;

    // One byte lane of every register, written only when its select is set
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                 lane_q         <= '0;
      else if (we_i && wsel_i[k])  lane_q[widx_i] <= wdat_i[k];
    end

    assign rdat_o[k] = lane_q[ridx_i];
  end

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone classic-cycle slave in front of a 16-entry register file.
// One wait state: ACK_O/ERR_O rise the cycle after the strobe is sampled,
// last one cycle, then the FSM parks in HOLD until the strobe is released.
// Optional mailbox interrupt: define WB_SLAVE_REGFILE_INTR_EN to turn
// reg[15] into CTRL (IE r/w, PEND write-1-to-clear) and drive INTR_O.
module wb_slave_regfile
  import wb_slave_regfile_pkg::*;
#(
  parameter int         aw        = ADDRESS_WIDTH - 1,
  parameter int         dw        = DATA_WIDTH - 1,
  parameter int         sw        = SELECT_WIDTH - 1,
  parameter logic [aw:0] BASE_ADDR = 'hF0,
  parameter int         DEPTH     = 16
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  wb_slave_regfile_if.slave  wb
);

  localparam int IW = $clog2(DEPTH);

  wbs_state_e    state_q;
  logic          ack_q, err_q;
  logic [dw:0]   dat_q;

  logic          req, hit, accept, wr_hit;
  logic [IW-1:0] idx;
  logic [dw:0]   mem_rdat, rd_data;

  assign req    = wb.CYC_I & wb.STB_I;
  assign hit    = (wb.ADR_I[aw:4] == BASE_ADDR[aw:4]);
  assign idx    = wb.ADR_I[IW-1:0];
  assign accept = (state_q == WBS_IDLE) & req;
  // Writes commit on the same edge that accepts the request
  assign wr_hit = accept & hit & wb.WE_I;

  wbs_regfile_mem #(.DEPTH(DEPTH), .LANES(sw + 1), .IW(IW)) u_mem (
    .clk_i  (CLK_I),
    .rst_ni (RST_I),
    .we_i   (wr_hit),
    .widx_i (idx),
    .wsel_i (wb.SEL_I),
    .wdat_i (wb.DAT_I),
    .ridx_i (idx),
    .rdat_o (mem_rdat)
  );

`ifdef WB_SLAVE_REGFILE_INTR_EN
  logic        ie_q, pend_q, intr_q;
  logic        ctrl_we, mbox_we;
  logic [dw:0] ctrl_word;

  assign ctrl_we = wr_hit & (idx == CTRL_IDX) & wb.SEL_I[0];
  assign mbox_we = wr_hit & (idx == MAILBOX_IDX);

  // Assemble the CTRL readback word from the live IE/PEND flops
  always_comb begin
    ctrl_word                = '0;
    ctrl_word[CTRL_IE_BIT]   = ie_q;
    ctrl_word[CTRL_PEND_BIT] = pend_q;
  end

  assign rd_data = (idx == CTRL_IDX) ? ctrl_word : mem_rdat;

  // CTRL flops; a mailbox write sets PEND after any clear so set wins
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      intr_q <= ie_q & pend_q;
      if (ctrl_we) begin
        ie_q <= wb.DAT_I[CTRL_IE_BIT];
        if (wb.DAT_I[CTRL_PEND_BIT]) pend_q <= 1'b0;
      end
      if (mbox_we) pend_q <= 1'b1;
    end
  end

  assign wb.INTR_O = intr_q;
`else
  assign rd_data   = mem_rdat;
  assign wb.INTR_O = 1'b0;
`endif

  // Bus FSM with registered ACK/ERR/DAT; one termination per strobe
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= WBS_IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        WBS_IDLE: if (accept) begin
          state_q <= WBS_RESP;
          ack_q   <= hit;
          err_q   <= ~hit;
          if (hit && !wb.WE_I) dat_q <= rd_data;
        end
        WBS_RESP: begin
          ack_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= req ? WBS_HOLD : WBS_IDLE;
        end
        WBS_HOLD: if (!req) state_q <= WBS_IDLE;
        default:  state_q <= WBS_IDLE;
      endcase
    end
  end

  assign wb.ACK_O = ack_q;
  assign wb.ERR_O = err_q;
  assign wb.DAT_O = dat_q;

endmodule
